alarm_setter: RTL and testbench

- Button-driven initiator for the alarm block's load interface.
- Lets the user edit an mm:ss alarm time as BCD digits through a small FSM.
- On confirmation, presents the digits on load_value_* with a one-cycle load_value_enable strobe; the alarm comparator's load port is the consumer.
- Keeps a committed copy of the last value sent, so a cancelled edit restores it.

---
 rtl/alarm_setter_if.sv | 27 ++
 rtl/alarm_setter.sv | 135 +++++++++++++
 tb/tb_alarm_setter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alarm_setter_if.sv
// Load bus from the alarm setter to the alarm comparator's load port.
// master drives the digits and commit strobe; slave consumes them.
interface alarm_setter_if #(
   parameter int unsigned BCD_W = 4
);
   logic             load_value_enable;
   logic [BCD_W-1:0] load_value_sec0;
   logic [BCD_W-1:0] load_value_sec1;
   logic [BCD_W-1:0] load_value_min0;
   logic [BCD_W-1:0] load_value_min1;

   modport master (
      output load_value_enable,
      output load_value_sec0,
      output load_value_sec1,
      output load_value_min0,
      output load_value_min1
   );

   modport slave (
      input load_value_enable,
      input load_value_sec0,
      input load_value_sec1,
      input load_value_min0,
      input load_value_min1
   );
endinterface

// File: rtl/alarm_setter.sv
// Button-driven mm:ss alarm editor. Edits BCD digits in two fields and
// commits them to the alarm load port with a one-cycle strobe.
module alarm_setter #(
   parameter int unsigned BCD_W    = 4,
   parameter int unsigned MAX_TENS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_mode,
   input  logic                 btn_inc,
   input  logic                 btn_dec,
   input  logic                 btn_cancel,
   alarm_setter_if.master       load_if,
   output logic                 editing,
   output logic [1:0]           field_sel
);

   typedef enum logic [1:0] {StIdle, StEditMin, StEditSec, StCommit} state_e;

   localparam logic [BCD_W-1:0] L_ZERO = '0;
   localparam logic [BCD_W-1:0] L_NINE = BCD_W'(9);
   localparam logic [BCD_W-1:0] L_TMAX = BCD_W'(MAX_TENS);

   state_e           r_state;
   logic [3:0]       r_btn;
   logic [3:0]       r_btn_q;
   logic             r_load_en;
   logic             r_editing;
   logic [1:0]       r_field_sel;
   logic [BCD_W-1:0] r_min1, r_min0, r_sec1, r_sec0;
   logic [BCD_W-1:0] r_cmin1, r_cmin0, r_csec1, r_csec0;

   logic [3:0] w_press;
   logic       w_cancel, w_mode, w_inc, w_dec;

   // Bit order {cancel, mode, inc, dec}
   assign w_press  = r_btn & ~r_btn_q;
   assign w_cancel = w_press[3];
   assign w_mode   = w_press[2];
   assign w_inc    = w_press[1] & ~w_press[0];
   assign w_dec    = w_press[0] & ~w_press[1];

   function automatic logic [2*BCD_W-1:0] f_inc(input logic [BCD_W-1:0] tens,
                                                 input logic [BCD_W-1:0] ones);
      if (ones != L_NINE) return {tens, ones + 1'b1};
      else if (tens >= L_TMAX) return {L_ZERO, L_ZERO};
      else return {tens + 1'b1, L_ZERO};
   endfunction

   function automatic logic [2*BCD_W-1:0] f_dec(input logic [BCD_W-1:0] tens,
                                                 input logic [BCD_W-1:0] ones);
      if (ones != L_ZERO) return {tens, ones - 1'b1};
      else if (tens == L_ZERO) return {L_TMAX, L_NINE};
      else return {tens - 1'b1, L_NINE};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_btn       <= 4'hf;
         r_btn_q     <= 4'hf;
         r_load_en   <= 1'b0;
         r_editing   <= 1'b0;
         r_field_sel <= 2'b00;
         r_min1      <= L_ZERO;
         r_min0      <= L_ZERO;
         r_sec1      <= L_ZERO;
         r_sec0      <= L_ZERO;
         r_cmin1     <= L_ZERO;
         r_cmin0     <= L_ZERO;
         r_csec1     <= L_ZERO;
         r_csec0     <= L_ZERO;
      end else begin
         r_btn     <= {btn_cancel, btn_mode, btn_inc, btn_dec};
         r_btn_q   <= r_btn;
         r_load_en <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_mode) begin
                  r_state     <= StEditMin;
                  r_editing   <= 1'b1;
                  r_field_sel <= 2'b01;
                  r_min1      <= r_cmin1;
                  r_min0      <= r_cmin0;
                  r_sec1      <= r_csec1;
                  r_sec0      <= r_csec0;
               end
            end
            StEditMin, StEditSec: begin
               if (w_cancel) begin
                  r_state     <= StIdle;
                  r_editing   <= 1'b0;
                  r_field_sel <= 2'b00;
                  r_min1      <= r_cmin1;
                  r_min0      <= r_cmin0;
                  r_sec1      <= r_csec1;
                  r_sec0      <= r_csec0;
               end else if (w_mode && r_state == StEditMin) begin
                  r_state     <= StEditSec;
                  r_field_sel <= 2'b10;
               end else if (w_mode) begin
                  r_state     <= StCommit;
                  r_editing   <= 1'b0;
                  r_field_sel <= 2'b00;
                  r_load_en   <= 1'b1;
                  r_cmin1     <= r_min1;
                  r_cmin0     <= r_min0;
                  r_csec1     <= r_sec1;
                  r_csec0     <= r_sec0;
               end else if (r_state == StEditMin) begin
                  if (w_inc) {r_min1, r_min0} <= f_inc(r_min1, r_min0);
                  else if (w_dec) {r_min1, r_min0} <= f_dec(r_min1, r_min0);
               end else begin
                  if (w_inc) {r_sec1, r_sec0} <= f_inc(r_sec1, r_sec0);
                  else if (w_dec) {r_sec1, r_sec0} <= f_dec(r_sec1, r_sec0);
               end
            end
            default: begin
               r_state     <= StIdle;
               r_editing   <= 1'b0;
               r_field_sel <= 2'b00;
            end
         endcase
      end
   end

   assign load_if.load_value_enable = r_load_en;
   assign load_if.load_value_min1   = r_min1;
   assign load_if.load_value_min0   = r_min0;
   assign load_if.load_value_sec1   = r_sec1;
   assign load_if.load_value_sec0   = r_sec0;
   assign editing                   = r_editing;
   assign field_sel                 = r_field_sel;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed bench for alarm_setter: an integer mm:ss model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_alarm_setter;

   localparam logic [3:0] C = 4'b1000;
   localparam logic [3:0] M = 4'b0100;
   localparam logic [3:0] I = 4'b0010;
   localparam logic [3:0] D = 4'b0001;
   localparam logic [3:0] N = 4'b0000;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode, btn_inc, btn_dec, btn_cancel;
   logic       editing;
   logic [1:0] field_sel;

   always #5 clk = ~clk;

   alarm_setter_if #(.BCD_W(4)) lif ();

   alarm_setter #(.BCD_W(4), .MAX_TENS(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .btn_dec   (btn_dec),
      .btn_cancel(btn_cancel),
      .load_if   (lif),
      .editing   (editing),
      .field_sel (field_sel)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_strobe = 0;
   int cyc = 0;
   int s0;

   // Model: 0 idle, 1 edit minutes, 2 edit seconds, 3 commit; values in 0..59
   int m_st, m_min, m_sec, c_min, c_sec;
   logic [3:0] p1, p2;

   task automatic model_step(input logic [3:0] b, input logic r);
      logic [3:0] pr;
      bit up, dn;
      if (r) begin
         m_st = 0; m_min = 0; m_sec = 0; c_min = 0; c_sec = 0;
         p1 = 4'hf; p2 = 4'hf;
         return;
      end
      pr = p1 & ~p2;
      p2 = p1;
      p1 = b;
      up = pr[1] && !pr[0];
      dn = pr[0] && !pr[1];
      case (m_st)
         0: if (pr[2]) begin m_st = 1; m_min = c_min; m_sec = c_sec; end
         1, 2: begin
            if (pr[3]) begin
               m_st = 0; m_min = c_min; m_sec = c_sec;
            end else if (pr[2]) begin
               if (m_st == 2) begin c_min = m_min; c_sec = m_sec; end
               m_st = m_st + 1;
            end else if (m_st == 1) begin
               if (up) m_min = (m_min + 1) % 60;
               else if (dn) m_min = (m_min + 59) % 60;
            end else begin
               if (up) m_sec = (m_sec + 1) % 60;
               else if (dn) m_sec = (m_sec + 59) % 60;
            end
         end
         default: m_st = 0;
      endcase
   endtask

   task automatic check();
      logic [19:0] got, exp;
      got = {lif.load_value_enable, editing, field_sel, lif.load_value_min1,
             lif.load_value_min0, lif.load_value_sec1, lif.load_value_sec0};
      exp = {(m_st == 3), (m_st == 1 || m_st == 2),
             (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00,
             4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL cycle %0d outputs {en,edit,sel,mm,ss}: got %h required %h",
                  cyc, got, exp);
      end
      if (lif.load_value_enable === 1'b1) n_strobe++;
   endtask

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic tick(input logic [3:0] b, input logic r);
      {btn_cancel, btn_mode, btn_inc, btn_dec} = b;
      rst = r;
      @(posedge clk);
      cyc++;
      model_step(b, r);
      #1 check();
   endtask

   task automatic press(input logic [3:0] b);
      tick(b, 1'b0);
      tick(N, 1'b0);
   endtask

   function automatic logic [15:0] mmss();
      return {lif.load_value_min1, lif.load_value_min0, lif.load_value_sec1,
              lif.load_value_sec0};
   endfunction

   initial begin
      rst = 1'b1;
      {btn_cancel, btn_mode, btn_inc, btn_dec} = N;

      // Mode held through reset must not act until released and re-pressed
      tick(M, 1'b1);
      tick(M, 1'b1);
      repeat (3) tick(M, 1'b0);
      lit("held_mode_no_edit", 32'(editing), 32'd0);
      tick(N, 1'b0);
      press(M);
      lit("repress_editing", 32'(editing), 32'd1);
      lit("repress_field_sel", 32'(field_sel), 32'd1);
      lit("repress_digits", 32'(mmss()), 32'h0000);

      // 03:59 commit with a single strobe
      repeat (3) press(I);
      press(M);
      press(D);
      s0 = n_strobe;
      tick(M, 1'b0);
      tick(N, 1'b0);
      lit("commit_strobe", 32'(lif.load_value_enable), 32'd1);
      lit("commit_digits", 32'(mmss()), 32'h0359);
      tick(N, 1'b0);
      lit("commit_one_pulse", 32'(n_strobe - s0), 32'd1);
      lit("after_commit_sel", 32'(field_sel), 32'd0);

      // Minutes wrap around 59/00
      press(M);
      repeat (5) press(D);
      lit("min_58", 32'(mmss()), 32'h5859);
      press(I);
      lit("min_59", 32'(mmss()), 32'h5959);
      press(I);
      lit("min_wrap_00", 32'(mmss()), 32'h0059);
      press(D);
      lit("min_wrap_59", 32'(mmss()), 32'h5959);
      press(C);
      lit("cancel_restore", 32'(mmss()), 32'h0359);

      // Commit 12:34, then a cancelled edit restores it
      press(M);
      repeat (9) press(I);
      press(M);
      repeat (25) press(D);
      press(M);
      tick(N, 1'b0);
      lit("commit_1234", 32'(mmss()), 32'h1234);
      press(M);
      repeat (5) press(I);
      s0 = n_strobe;
      press(C);
      lit("cancel_no_strobe", 32'(n_strobe - s0), 32'd0);
      lit("cancel_digits", 32'(mmss()), 32'h1234);
      lit("cancel_editing", 32'(editing), 32'd0);

      // Same-cycle presses
      press(M);
      press(M);
      press(I | D);
      lit("incdec_unchanged", 32'(mmss()), 32'h1234);
      s0 = n_strobe;
      press(C | M);
      lit("cancel_mode_idle", 32'(editing), 32'd0);
      lit("cancel_mode_no_strobe", 32'(n_strobe - s0), 32'd0);
      press(M);
      press(M | I);
      lit("mode_inc_sel", 32'(field_sel), 32'd2);
      lit("mode_inc_min", 32'(mmss()), 32'h1234);
      press(C);

      // Reset during EDIT_SEC with 07:45 committed
      press(M);
      repeat (5) press(D);
      press(M);
      repeat (11) press(I);
      press(M);
      tick(N, 1'b0);
      lit("commit_0745", 32'(mmss()), 32'h0745);
      press(M);
      press(M);
      lit("edit_sec_before_rst", 32'(field_sel), 32'd2);
      s0 = n_strobe;
      tick(N, 1'b1);
      lit("rst_editing", 32'(editing), 32'd0);
      lit("rst_digits", 32'(mmss()), 32'h0000);
      repeat (3) tick(N, 1'b0);
      lit("rst_no_strobe", 32'(n_strobe - s0), 32'd0);
      press(M);
      lit("rst_committed_clear", 32'(mmss()), 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
